// File: rtl/alu_issue_stage_if.sv
// Handshake and payload bundle between the register-read stage, the
// ALU issue stage and the execute stage.
interface alu_issue_stage_if #(
    parameter int unsigned XLEN = 32
);
    // Upstream side: instruction, operands and PC in; ready back out.
    logic            valid_in;
    logic            ready_out;
    logic [31:0]     instr_in;
    logic [XLEN-1:0] pc_in;
    logic [XLEN-1:0] rs1_data_in;
    logic [XLEN-1:0] rs2_data_in;
    logic            flush_in;

    // Downstream side: issued ALU operation towards the execute stage.
    logic            valid_out;
    logic            ready_in;
    logic [XLEN-1:0] op_1_out;
    logic [XLEN-1:0] op_2_out;
    logic [3:0]      opcode_out;
    logic [4:0]      rd_out;
    logic            wb_en_out;
    logic            illegal_out;

    // Environment view: drives instructions and ready, observes the issue.
    modport master (
        output valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in,
               flush_in, ready_in,
        input  ready_out, valid_out, op_1_out, op_2_out, opcode_out,
               rd_out, wb_en_out, illegal_out
    );

    // Stage view.
    modport slave (
        input  valid_in, instr_in, pc_in, rs1_data_in, rs2_data_in,
               flush_in, ready_in,
        output ready_out, valid_out, op_1_out, op_2_out, opcode_out,
               rd_out, wb_en_out, illegal_out
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Decode/issue stage: decodes RV32I OP, OP-IMM, LUI and AUIPC into an ALU
// opcode plus two operands and holds them in a single output register
// with valid/ready handshakes and a synchronous flush.
module alu_issue_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    alu_issue_stage_if.slave  bus
);

    localparam int unsigned OPC_W  = 4;
    localparam int unsigned RD_W   = 5;

    localparam logic [6:0] MAJ_OP     = 7'b0110011;
    localparam logic [6:0] MAJ_OP_IMM = 7'b0010011;
    localparam logic [6:0] MAJ_LUI    = 7'b0110111;
    localparam logic [6:0] MAJ_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0]  op_1;
        logic [XLEN-1:0]  op_2;
        logic [OPC_W-1:0] opcode;
        logic [RD_W-1:0]  rd;
        logic             wb_en;
        logic             illegal;
    } issue_t;

    issue_t dec_c;
    issue_t payload_d, payload_q;
    logic   valid_d, valid_q;
    logic   ready_c;
    logic   load_c;
    logic   drain_c;

    logic [6:0]      major;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;

    assign major  = bus.instr_in[6:0];
    assign funct3 = bus.instr_in[14:12];
    assign funct7 = bus.instr_in[31:25];
    assign rd     = bus.instr_in[11:7];
    assign imm_i  = XLEN'($signed(bus.instr_in[31:20]));
    assign imm_u  = XLEN'({bus.instr_in[31:12], 12'b0});

    // Combinational decode of the instruction currently presented upstream.
    always_comb begin
        logic            legal;
        logic            alt;
        logic            is_shift;
        logic [XLEN-1:0] op_1;
        logic [XLEN-1:0] op_2;
        logic [2:0]      f3;

        legal    = 1'b0;
        alt      = 1'b0;
        is_shift = (funct3 == F3_SLL) || (funct3 == F3_SR);
        op_1     = '0;
        op_2     = '0;
        f3       = F3_ADD;
        dec_c    = '0;

        case (major)
            MAJ_OP: begin
                op_1  = bus.rs1_data_in;
                op_2  = is_shift ? XLEN'(bus.rs2_data_in[4:0]) : bus.rs2_data_in;
                alt   = bus.instr_in[30];
                f3    = funct3;
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
            end
            MAJ_OP_IMM: begin
                op_1 = bus.rs1_data_in;
                f3   = funct3;
                if (funct3 == F3_SLL) begin
                    op_2  = XLEN'(bus.instr_in[24:20]);
                    alt   = bus.instr_in[30];
                    legal = (funct7 == F7_BASE);
                end else if (funct3 == F3_SR) begin
                    op_2  = XLEN'(bus.instr_in[24:20]);
                    alt   = bus.instr_in[30];
                    legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                end else begin
                    // Non-shift immediates never use imm[10] as alt: ADDI stays ADD.
                    op_2  = imm_i;
                    legal = 1'b1;
                end
            end
            MAJ_LUI: begin
                op_2  = imm_u;
                legal = 1'b1;
            end
            MAJ_AUIPC: begin
                op_1  = bus.pc_in;
                op_2  = imm_u;
                legal = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase

        // Illegal instructions still issue, but with zeroed operation fields.
        if (legal) begin
            dec_c.op_1   = op_1;
            dec_c.op_2   = op_2;
            dec_c.opcode = {alt, f3};
        end
        dec_c.rd      = rd;
        dec_c.wb_en   = legal && (rd != '0);
        dec_c.illegal = !legal;
    end

    // Handshake qualifiers; flush never gates ready, only the load.
    always_comb begin
        ready_c = !valid_q || bus.ready_in;
        load_c  = bus.valid_in && ready_c && !bus.flush_in;
        drain_c = valid_q && bus.ready_in;
    end

    // Next state of the output register: load wins, otherwise flush/drain empty it.
    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (load_c) begin
            valid_d   = 1'b1;
            payload_d = dec_c;
        end else if (bus.flush_in || drain_c) begin
            valid_d   = 1'b0;
        end
    end

    // Output pipeline register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign bus.ready_out   = ready_c;
    assign bus.valid_out   = valid_q;
    assign bus.op_1_out    = payload_q.op_1;
    assign bus.op_2_out    = payload_q.op_2;
    assign bus.opcode_out  = payload_q.opcode;
    assign bus.rd_out      = payload_q.rd;
    assign bus.wb_en_out   = payload_q.wb_en;
    assign bus.illegal_out = payload_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic,
// all compared against a behavioural decode/handshake model.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  opc;
        logic [4:0]  rd;
        logic        wb;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic m_valid;
    exp_t m_q;

    alu_issue_stage_if bus();

    alu_issue_stage dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference decode written from the instruction-set rules.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        int unsigned f3;
        int unsigned f7;
        logic [31:0] imm;
        e   = '0;
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        imm = 32'($signed(ins) >>> 20);
        e.rd  = ins[11:7];
        e.ill = 1'b1;
        case (ins[6:0])
            7'h33: begin
                if (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5))) begin
                    e.ill = 1'b0;
                    e.op1 = r1;
                    e.op2 = (f3 == 1 || f3 == 5) ? (r2 % 32) : r2;
                    e.opc = 4'(f3 + ((f7 == 32) ? 8 : 0));
                end
            end
            7'h13: begin
                if (f3 == 1) begin
                    if (f7 == 0) begin
                        e.ill = 1'b0; e.op1 = r1; e.op2 = 32'(ins[24:20]); e.opc = 4'd1;
                    end
                end else if (f3 == 5) begin
                    if (f7 == 0 || f7 == 32) begin
                        e.ill = 1'b0; e.op1 = r1; e.op2 = 32'(ins[24:20]);
                        e.opc = (f7 == 32) ? 4'd13 : 4'd5;
                    end
                end else begin
                    e.ill = 1'b0; e.op1 = r1; e.op2 = imm; e.opc = 4'(f3);
                end
            end
            7'h37: begin
                e.ill = 1'b0; e.op1 = 32'd0; e.op2 = ins & 32'hFFFF_F000;
            end
            7'h17: begin
                e.ill = 1'b0; e.op1 = pc; e.op2 = ins & 32'hFFFF_F000;
            end
            default: ;
        endcase
        e.wb = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    task automatic check_outputs();
        chk("valid_out",   32'(bus.valid_out),   32'(m_valid));
        chk("op_1_out",    bus.op_1_out,         m_q.op1);
        chk("op_2_out",    bus.op_2_out,         m_q.op2);
        chk("opcode_out",  32'(bus.opcode_out),  32'(m_q.opc));
        chk("rd_out",      32'(bus.rd_out),      32'(m_q.rd));
        chk("wb_en_out",   32'(bus.wb_en_out),   32'(m_q.wb));
        chk("illegal_out", 32'(bus.illegal_out), 32'(m_q.ill));
    endtask

    // One cycle: drive at negedge, check ready, clock, update model, check outputs.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2,
                        input logic rdy, input logic fl);
        logic m_ready;
        bus.valid_in    = v;
        bus.instr_in    = ins;
        bus.pc_in       = pc;
        bus.rs1_data_in = r1;
        bus.rs2_data_in = r2;
        bus.ready_in    = rdy;
        bus.flush_in    = fl;
        #1;
        m_ready = !m_valid || rdy;
        chk("ready_out", 32'(bus.ready_out), 32'(m_ready));
        @(posedge clk);
        if (v && m_ready && !fl) begin
            m_valid = 1'b1;
            m_q     = ref_decode(ins, pc, r1, r2);
        end else if (fl || (m_valid && rdy)) begin
            m_valid = 1'b0;
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  f7;
        int unsigned k;
        w = $urandom();
        k = $urandom_range(0, 2);
        f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : 7'($urandom());
        case ($urandom_range(0, 5))
            0: w = {f7, w[24:7], 7'h33};
            1: w = {w[31:7], 7'h13};
            2: w = {f7, w[24:15], ($urandom_range(0, 1) != 0) ? 3'b001 : 3'b101, w[11:7], 7'h13};
            3: w = {w[31:7], 7'h37};
            4: w = {w[31:7], 7'h17};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        logic [31:0] ins;
        checks  = 0;
        errors  = 0;
        m_valid = 1'b0;
        m_q     = '0;
        rst_n   = 1'b0;
        bus.valid_in = 1'b0; bus.instr_in = '0; bus.pc_in = '0;
        bus.rs1_data_in = '0; bus.rs2_data_in = '0;
        bus.ready_in = 1'b0; bus.flush_in = 1'b0;

        // Reset state
        #2;
        chk("rst_ready_out", 32'(bus.ready_out), 32'd1);
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD / SUB
        step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("add_valid", 32'(bus.valid_out), 32'd1);
        chk("add_opc",   32'(bus.opcode_out), 32'h0);
        chk("add_op1",   bus.op_1_out, 32'd5);
        chk("add_op2",   bus.op_2_out, 32'd7);
        chk("add_rd",    32'(bus.rd_out), 32'd3);
        chk("add_wb",    32'(bus.wb_en_out), 32'd1);
        step(1'b1, 32'h402081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("sub_opc",   32'(bus.opcode_out), 32'h8);

        // ADDI with negative immediate stays ADD
        step(1'b1, 32'hFFF00093, 32'h0, 32'd0, 32'd9, 1'b1, 1'b0);
        chk("addi_opc",  32'(bus.opcode_out), 32'h0);
        chk("addi_op2",  bus.op_2_out, 32'hFFFF_FFFF);
        chk("addi_wb",   32'(bus.wb_en_out), 32'd1);

        // Shifts
        step(1'b1, 32'h40335293, 32'h0, 32'h8000_0000, 32'd0, 1'b1, 1'b0);
        chk("srai_opc",  32'(bus.opcode_out), 32'hD);
        chk("srai_op2",  bus.op_2_out, 32'd3);
        step(1'b1, 32'h40131293, 32'h0, 32'd11, 32'd0, 1'b1, 1'b0);
        chk("slli_bad_ill", 32'(bus.illegal_out), 32'd1);
        chk("slli_bad_wb",  32'(bus.wb_en_out), 32'd0);
        chk("slli_bad_opc", 32'(bus.opcode_out), 32'd0);

        // LUI / AUIPC
        step(1'b1, 32'h123450B7, 32'h0, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
        chk("lui_op1",   bus.op_1_out, 32'd0);
        chk("lui_op2",   bus.op_2_out, 32'h1234_5000);
        step(1'b1, 32'h00001097, 32'h100, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("auipc_op1", bus.op_1_out, 32'h100);
        chk("auipc_op2", bus.op_2_out, 32'h1000);

        // x0 destination
        step(1'b1, 32'h00000033, 32'h0, 32'd1, 32'd2, 1'b1, 1'b0);
        chk("x0_wb",     32'(bus.wb_en_out), 32'd0);
        chk("x0_ill",    32'(bus.illegal_out), 32'd0);

        // Back-pressure: ADD held while SUB waits, then SUB moves exactly once
        step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h402081B3, 32'h0, 32'd5, 32'd7, 1'b0, 1'b0);
            chk("bp_hold_opc",   32'(bus.opcode_out), 32'h0);
            chk("bp_hold_valid", 32'(bus.valid_out), 32'd1);
            chk("bp_ready_out",  32'(bus.ready_out), 32'd0);
        end
        step(1'b1, 32'h402081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        chk("bp_sub_opc",   32'(bus.opcode_out), 32'h8);
        chk("bp_sub_valid", 32'(bus.valid_out), 32'd1);
        step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("bp_no_dup",    32'(bus.valid_out), 32'd0);

        // Flush with a held and an incoming instruction
        step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b0);
        step(1'b1, 32'h402081B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b1);
        chk("flush_valid", 32'(bus.valid_out), 32'd0);
        chk("flush_drop",  32'(bus.opcode_out), 32'h0);
        step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1, 1'b0);
        chk("flush_stays", 32'(bus.valid_out), 32'd0);

        // Asynchronous reset mid-stream
        step(1'b1, 32'h123450B7, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        m_valid = 1'b0;
        m_q     = '0;
        chk("midrst_ready", 32'(bus.ready_out), 32'd1);
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            ins = rand_instr();
            step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0, ins, $urandom(), $urandom(),
                 $urandom(), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
